// File: rtl/gfx_wb_ctrl.sv
// gfx_wb_ctrl: Wishbone register block in front of the gfxdemo pixel pipeline.
// Holds control, scroll and a 16-entry RGB444 palette, plus vsync status and
// interrupt. Control and scroll writes land in pending registers and are
// copied to the active outputs only on vsync_pulse, so the pixel pipeline
// never sees a mid-frame change.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   wb__adr/dat_w/sel     wishbone address, write data, byte enables
//   wb__cyc/stb/we        wishbone cycle, strobe, write enable
//   wb__dat_r/ack         wishbone read data (valid with ack), acknowledge
//   vsync_pulse           one-cycle start-of-vblank pulse
//   gfx_enable/gfx_mode   active enable and mode to the pixel pipeline
//   scroll_x/scroll_y     active scroll offsets
//   pal_idx/pal_rgb       palette lookup port, one cycle latency
//   irq                   irq[0] = vsync interrupt, irq[2:1] tied low
module gfx_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ID_VALUE  = 32'h6766_7801
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb__adr,
  input  logic [31:0] wb__dat_w,
  output logic [31:0] wb__dat_r,
  input  logic [3:0]  wb__sel,
  input  logic        wb__cyc,
  input  logic        wb__stb,
  input  logic        wb__we,
  output logic        wb__ack,
  input  logic        vsync_pulse,
  output logic        gfx_enable,
  output logic [2:0]  gfx_mode,
  output logic [9:0]  scroll_x,
  output logic [9:0]  scroll_y,
  input  logic [3:0]  pal_idx,
  output logic [11:0] pal_rgb,
  output logic [2:0]  irq
);

  logic        ack_reg;
  logic [31:0] dat_r_reg;
  logic        en_p_reg, en_a_reg;
  logic [2:0]  mode_p_reg, mode_a_reg;
  logic [9:0]  sx_p_reg, sx_a_reg, sy_p_reg, sy_a_reg;
  logic        irq_en_reg;
  logic        vsync_pending_reg;
  logic [15:0] frame_cnt_reg;
  logic        irq_reg;
  logic [11:0] pal_rgb_reg;
  logic [11:0] palette [16];

  logic [5:0]  word;
  logic        hit, req, wr, is_pal;
  logic        wr_ctrl, wr_scroll, wr_status, wr_pal;
  logic [3:0]  pal_widx;
  logic [11:0] pal_wdata;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign word   = wb__adr[7:2];
  assign hit    = (wb__adr[31:8] == BASE_ADDR[31:8]);
  assign is_pal = (word[5:4] == 2'b01);
  // The ack cycle itself never starts a new access, limiting the bus to
  // one access per two cycles even with stb held high.
  assign req    = wb__cyc & wb__stb & hit & ~ack_reg;
  assign wr     = req & wb__we;

  assign wr_ctrl   = wr & (word == 6'h00);
  assign wr_scroll = wr & (word == 6'h01);
  assign wr_status = wr & (word == 6'h02);
  assign wr_pal    = wr & is_pal;
  assign pal_widx  = word[3:0];

  // Byte-lane merge of the palette entry being written.
  always_comb begin
    pal_wdata = palette[pal_widx];
    if (wb__sel[0]) pal_wdata[7:0]  = wb__dat_w[7:0];
    if (wb__sel[1]) pal_wdata[11:8] = wb__dat_w[11:8];
  end

  // CTRL/SCROLL read back the pending values, not the active ones.
  always_comb begin
    rd_data = 32'h0;
    if (is_pal) begin
      rd_data = {20'h0, palette[word[3:0]]};
    end else begin
      case (word)
        6'h00:   rd_data = {23'h0, irq_en_reg, 4'h0, mode_p_reg, en_p_reg};
        6'h01:   rd_data = {6'h0, sy_p_reg, 6'h0, sx_p_reg};
        6'h02:   rd_data = {frame_cnt_reg, 15'h0, vsync_pending_reg};
        6'h03:   rd_data = ID_VALUE;
        default: rd_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_reg           <= 1'b0;
      dat_r_reg         <= 32'h0;
      en_p_reg          <= 1'b0;
      en_a_reg          <= 1'b0;
      mode_p_reg        <= 3'h0;
      mode_a_reg        <= 3'h0;
      sx_p_reg          <= 10'h0;
      sx_a_reg          <= 10'h0;
      sy_p_reg          <= 10'h0;
      sy_a_reg          <= 10'h0;
      irq_en_reg        <= 1'b0;
      vsync_pending_reg <= 1'b0;
      frame_cnt_reg     <= 16'h0;
      irq_reg           <= 1'b0;
    end else begin
      ack_reg   <= req;
      dat_r_reg <= (req & ~wb__we) ? rd_data : 32'h0;

      if (wr_ctrl) begin
        if (wb__sel[0]) {mode_p_reg, en_p_reg} <= wb__dat_w[3:0];
        if (wb__sel[1]) irq_en_reg <= wb__dat_w[8];
      end
      if (wr_scroll) begin
        if (wb__sel[0]) sx_p_reg[7:0] <= wb__dat_w[7:0];
        if (wb__sel[1]) sx_p_reg[9:8] <= wb__dat_w[9:8];
        if (wb__sel[2]) sy_p_reg[7:0] <= wb__dat_w[23:16];
        if (wb__sel[3]) sy_p_reg[9:8] <= wb__dat_w[25:24];
      end

      // Non-blocking copy: a write on the same edge is not yet visible,
      // so the active side takes the pre-write pending value.
      if (vsync_pulse) begin
        en_a_reg      <= en_p_reg;
        mode_a_reg    <= mode_p_reg;
        sx_a_reg      <= sx_p_reg;
        sy_a_reg      <= sy_p_reg;
        frame_cnt_reg <= frame_cnt_reg + 16'h1;
      end

      // Set has priority over a coincident write-1-to-clear.
      if (vsync_pulse)
        vsync_pending_reg <= 1'b1;
      else if (wr_status & wb__sel[0] & wb__dat_w[0])
        vsync_pending_reg <= 1'b0;

      irq_reg <= vsync_pending_reg & irq_en_reg;
    end
  end

  // Palette storage and lookup. The lookup reads the pre-write contents on
  // a same-edge write, so the new value appears one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      pal_rgb_reg <= 12'h0;
      for (int i = 0; i < 16; i++) begin
        palette[i] <= {3{4'(i)}};
      end
    end else begin
      pal_rgb_reg <= palette[pal_idx];
      if (wr_pal) palette[pal_widx] <= pal_wdata;
    end
  end

  assign wb__ack    = ack_reg;
  assign wb__dat_r  = dat_r_reg;
  assign gfx_enable = en_a_reg;
  assign gfx_mode   = mode_a_reg;
  assign scroll_x   = sx_a_reg;
  assign scroll_y   = sy_a_reg;
  assign pal_rgb    = pal_rgb_reg;
  assign irq        = {2'b00, irq_reg};

  assign unused_bits = ^{wb__adr[1:0], wb__dat_w[15:12], wb__dat_w[31:26]};

endmodule

// File: tb/tb_gfx_wb_ctrl.sv
// tb_gfx_wb_ctrl: directed self-checking bench for gfx_wb_ctrl.
// Walks reset state, ID/palette reads, shadowed CTRL/SCROLL updates,
// vsync status/interrupt, frame counter wrap, byte enables, decode misses,
// back-to-back ack spacing and reset in the middle of an access.
module tb_gfx_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb__adr, wb__dat_w, wb__dat_r;
  logic [3:0]  wb__sel;
  logic        wb__cyc, wb__stb, wb__we, wb__ack;
  logic        vsync_pulse;
  logic        gfx_enable;
  logic [2:0]  gfx_mode;
  logic [9:0]  scroll_x, scroll_y;
  logic [3:0]  pal_idx;
  logic [11:0] pal_rgb;
  logic [2:0]  irq;

  int n_vec  = 0;
  int n_miss = 0;
  int frames = 0;
  logic [31:0] rdata;

  localparam logic [31:0] BASE = 32'h3000_0000;

  gfx_wb_ctrl dut (
    .clk(clk), .reset(reset),
    .wb__adr(wb__adr), .wb__dat_w(wb__dat_w), .wb__dat_r(wb__dat_r),
    .wb__sel(wb__sel), .wb__cyc(wb__cyc), .wb__stb(wb__stb),
    .wb__we(wb__we), .wb__ack(wb__ack), .vsync_pulse(vsync_pulse),
    .gfx_enable(gfx_enable), .gfx_mode(gfx_mode),
    .scroll_x(scroll_x), .scroll_y(scroll_y),
    .pal_idx(pal_idx), .pal_rgb(pal_rgb), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_read(input logic [31:0] addr, output logic [31:0] data, input string tag);
    int n;
    wb__adr = addr; wb__cyc = 1'b1; wb__stb = 1'b1; wb__we = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!wb__ack && n < 4);
    chk({tag, " ack latency"}, 32'(n), 32'd1);
    data = wb__dat_r;
    wb__cyc = 1'b0; wb__stb = 1'b0;
    tick();
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input logic vs, input string tag);
    int n;
    wb__adr = addr; wb__dat_w = data; wb__sel = sel;
    wb__cyc = 1'b1; wb__stb = 1'b1; wb__we = 1'b1;
    vsync_pulse = vs;
    n = 0;
    do begin
      tick();
      vsync_pulse = 1'b0;
      n++;
    end while (!wb__ack && n < 4);
    chk({tag, " ack latency"}, 32'(n), 32'd1);
    wb__cyc = 1'b0; wb__stb = 1'b0; wb__we = 1'b0;
    tick();
  endtask

  task automatic pulse_vsync();
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
    frames++;
  endtask

  initial begin
    reset = 1'b1; wb__adr = '0; wb__dat_w = '0; wb__sel = '0;
    wb__cyc = 1'b0; wb__stb = 1'b0; wb__we = 1'b0;
    vsync_pulse = 1'b0; pal_idx = 4'h0;
    tick(); tick(); tick();

    // Reset state
    chk("rst ack", 32'(wb__ack), 32'd0);
    chk("rst dat_r", wb__dat_r, 32'h0);
    chk("rst enable", 32'(gfx_enable), 32'd0);
    chk("rst mode", 32'(gfx_mode), 32'd0);
    chk("rst scroll_x", 32'(scroll_x), 32'd0);
    chk("rst scroll_y", 32'(scroll_y), 32'd0);
    chk("rst pal_rgb", 32'(pal_rgb), 32'd0);
    chk("rst irq", 32'(irq), 32'd0);
    reset = 1'b0;
    tick();

    // ID and palette reset contents
    wb_read(BASE + 32'h0C, rdata, "id");
    chk("id data", rdata, 32'h6766_7801);
    wb_read(BASE + 32'h44, rdata, "pal1");
    chk("pal1 data", rdata, 32'h0000_0111);
    pal_idx = 4'd5;
    tick();
    chk("lookup 5", 32'(pal_rgb), 32'h555);

    // Shadowed CTRL/SCROLL
    wb_write(BASE + 32'h00, 32'h0000_0007, 4'hF, 1'b0, "wr ctrl");
    wb_write(BASE + 32'h04, 32'h0020_0010, 4'hF, 1'b0, "wr scroll");
    chk("pre-vs enable", 32'(gfx_enable), 32'd0);
    chk("pre-vs scroll_x", 32'(scroll_x), 32'd0);
    pulse_vsync();
    chk("vs enable", 32'(gfx_enable), 32'd1);
    chk("vs mode", 32'(gfx_mode), 32'd3);
    chk("vs scroll_x", 32'(scroll_x), 32'h010);
    chk("vs scroll_y", 32'(scroll_y), 32'h020);
    chk("irq disabled", 32'(irq), 32'd0);
    wb_read(BASE + 32'h00, rdata, "rd ctrl");
    chk("ctrl readback", rdata, 32'h0000_0007);

    // Write coincident with vsync: old pending value goes active
    wb_write(BASE + 32'h04, 32'h0000_0005, 4'hF, 1'b1, "wr scroll+vs");
    frames++;
    chk("same-edge scroll_x", 32'(scroll_x), 32'h010);
    wb_read(BASE + 32'h04, rdata, "rd scroll");
    chk("scroll readback", rdata, 32'h0000_0005);
    pulse_vsync();
    chk("next-vs scroll_x", 32'(scroll_x), 32'h005);
    chk("next-vs scroll_y", 32'(scroll_y), 32'h000);

    // Status and interrupt
    wb_write(BASE + 32'h08, 32'h1, 4'hF, 1'b0, "clr status");
    wb_read(BASE + 32'h08, rdata, "rd status0");
    chk("status after clear", rdata, {16'(frames), 16'h0000});
    wb_write(BASE + 32'h00, 32'h0000_0107, 4'hF, 1'b0, "wr ctrl irq");
    pulse_vsync();
    chk("irq latency", 32'(irq), 32'd0);
    tick();
    chk("irq set", 32'(irq), 32'd1);
    wb_read(BASE + 32'h08, rdata, "rd status1");
    chk("status pending", rdata, {16'(frames), 16'h0001});
    wb_write(BASE + 32'h08, 32'h1, 4'h1, 1'b0, "w1c status");
    chk("irq cleared", 32'(irq), 32'd0);
    wb_write(BASE + 32'h08, 32'h1, 4'h1, 1'b1, "w1c+vs status");
    frames++;
    wb_read(BASE + 32'h08, rdata, "rd status2");
    chk("set wins", rdata, {16'(frames), 16'h0001});

    // Frame counter wrap
    vsync_pulse = 1'b1;
    for (int i = frames; i < 65536; i++) tick();
    vsync_pulse = 1'b0;
    frames = 0;
    wb_read(BASE + 32'h08, rdata, "rd status wrap");
    chk("frame wrap", rdata, 32'h0000_0001);

    // Palette byte enables
    wb_write(BASE + 32'h4C, 32'h0000_0ABC, 4'b0001, 1'b0, "wr pal3");
    wb_read(BASE + 32'h4C, rdata, "rd pal3");
    chk("pal3 sel", rdata, 32'h0000_03BC);
    pal_idx = 4'd3;
    tick();
    chk("lookup 3", 32'(pal_rgb), 32'h3BC);

    // Same-edge lookup and write of one entry
    pal_idx = 4'd7;
    tick();
    wb__adr = BASE + 32'h5C; wb__dat_w = 32'h0000_0FED; wb__sel = 4'hF;
    wb__cyc = 1'b1; wb__stb = 1'b1; wb__we = 1'b1;
    tick();
    chk("pal7 wr ack", 32'(wb__ack), 32'd1);
    chk("lookup 7 old", 32'(pal_rgb), 32'h777);
    wb__cyc = 1'b0; wb__stb = 1'b0; wb__we = 1'b0;
    tick();
    chk("lookup 7 new", 32'(pal_rgb), 32'hFED);

    // Unmapped offset inside the block
    wb_read(BASE + 32'h20, rdata, "rd hole");
    chk("hole data", rdata, 32'h0);

    // Outside decode range: never acked
    wb__adr = BASE + 32'h100; wb__cyc = 1'b1; wb__stb = 1'b1; wb__we = 1'b0;
    tick(); tick(); tick();
    chk("no-decode ack", 32'(wb__ack), 32'd0);
    wb__cyc = 1'b0; wb__stb = 1'b0;
    tick();

    // stb held continuously: ack every other cycle
    wb__adr = BASE + 32'h00; wb__cyc = 1'b1; wb__stb = 1'b1; wb__we = 1'b0;
    chk("held ack c0", 32'(wb__ack), 32'd0);
    tick();
    chk("held ack c1", 32'(wb__ack), 32'd1);
    tick();
    chk("held ack c2", 32'(wb__ack), 32'd0);
    tick();
    chk("held ack c3", 32'(wb__ack), 32'd1);
    wb__cyc = 1'b0; wb__stb = 1'b0;
    tick();

    // Reset during a pending write
    wb__adr = BASE + 32'h04; wb__dat_w = 32'h0000_03FF; wb__sel = 4'hF;
    wb__cyc = 1'b1; wb__stb = 1'b1; wb__we = 1'b1;
    reset = 1'b1;
    tick();
    chk("reset mid ack", 32'(wb__ack), 32'd0);
    chk("reset mid enable", 32'(gfx_enable), 32'd0);
    reset = 1'b0;
    wb__cyc = 1'b0; wb__stb = 1'b0; wb__we = 1'b0;
    tick();
    wb_read(BASE + 32'h04, rdata, "rd scroll post-rst");
    chk("scroll discarded", rdata, 32'h0);
    wb_read(BASE + 32'h4C, rdata, "rd pal3 post-rst");
    chk("pal3 reset", rdata, 32'h0000_0333);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
